// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the ALU share arbiter.
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned ALU_SH_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [ALU_OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] OP_SLL = 5'b00100;
  localparam logic [ALU_OP_W-1:0] OP_SRA = 5'b00101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // True for the six opcodes the ALU implements.
  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  // True for opcodes whose ALU overflow flag is meaningful.
  function automatic logic op_has_ovf(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response handshakes plus the ALU-facing bus of the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 5
);
  localparam int unsigned SH_W = 5;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OP_W-1:0]  req0_op;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_b;
  logic [SH_W-1:0]  req0_shamt;
  logic [SH_W-1:0]  req1_shamt;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SH_W-1:0]  alu_shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ovf;
  logic             rsp_err;

  // Arbiter side.
  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
           req0_shamt, req1_shamt, alu_result, alu_overflow, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, alu_shamt,
           rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  // Requesters plus ALU side.
  modport master (
    output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
           req0_shamt, req1_shamt, alu_result, alu_overflow, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, alu_shamt,
           rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: prio breaks ties, a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  // One-hot grant from request vector and priority pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, one EXEC cycle,
// registered result returned over a per-requester valid/ready response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned OP_W  = ALU_OP_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_share_arbiter_if.slave   bus,
  output logic                 busy
);

  localparam int unsigned SH_W = ALU_SH_W;

  state_e           state_q;
  state_e           state_d;
  logic             prio_q;
  logic             grant_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SH_W-1:0]  shamt_q;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;
  logic             err_q;

  logic [1:0]       grant_c;
  logic             sel_c;
  logic             legal_c;
  logic             accept_c;
  logic             capture_c;
  logic             done_c;
  logic [OP_W-1:0]  op_sel_c;
  logic [WIDTH-1:0] a_sel_c;
  logic [WIDTH-1:0] b_sel_c;
  logic [SH_W-1:0]  shamt_sel_c;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .prio  (prio_q),
    .grant (grant_c)
  );

  // Select the winning requester's payload.
  always_comb begin
    sel_c       = grant_c[1];
    op_sel_c    = sel_c ? bus.req1_op    : bus.req0_op;
    a_sel_c     = sel_c ? bus.req1_a     : bus.req0_a;
    b_sel_c     = sel_c ? bus.req1_b     : bus.req0_b;
    shamt_sel_c = sel_c ? bus.req1_shamt : bus.req0_shamt;
    legal_c     = op_is_legal(ALU_OP_W'(op_sel_c));
  end

  // Next-state and datapath enables.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          accept_c = 1'b1;
          state_d  = legal_c ? EXEC : RESP;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, result capture and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        grant_q <= sel_c;
        op_q    <= op_sel_c;
        a_q     <= a_sel_c;
        b_q     <= b_sel_c;
        shamt_q <= shamt_sel_c;
        data_q  <= '0;
        ovf_q   <= 1'b0;
        err_q   <= ~legal_c;
      end
      if (capture_c) begin
        data_q <= bus.alu_result;
        ovf_q  <= op_has_ovf(ALU_OP_W'(op_q)) & bus.alu_overflow;
      end
      if (done_c) begin
        prio_q <= ~grant_q;
      end
    end
  end

  // Output drive; req_ready is the same-cycle accept and is held low in reset.
  always_comb begin
    bus.req_ready = (state_q == IDLE && reset_n) ? grant_c : 2'b00;
    bus.rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_data  = data_q;
    bus.rsp_ovf   = ovf_q;
    bus.rsp_err   = err_q;
    bus.alu_op    = op_q;
    bus.alu_a     = a_q;
    bus.alu_b     = b_q;
    bus.alu_shamt = shamt_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a transaction-level reference model.
module tb_alu_share_arbiter;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } op_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic        ovf;
    logic        err;
    int          lat;
  } rl_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  op_t  q0[$];
  op_t  q1[$];
  int   grant_log[$];
  rl_t  rsp_log[$];
  int   acc_at[2];

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference ALU; overflow is deliberately 1 for non-add/sub so masking is visible.
  function automatic logic [32:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic v;
    r = 32'hDEAD_BEEF;
    v = 1'b1;
    case (op)
      5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = $signed(a) >>> sh;
      default: ;
    endcase
    return {v, r};
  endfunction

  always_comb {bus.alu_overflow, bus.alu_result} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh);
    op_t o;
    o.op = op; o.a = a; o.b = b; o.sh = sh;
    return o;
  endfunction

  function automatic logic [1:0] mgrant(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Reference model: one outstanding transaction, response window opens a fixed
  // number of cycles after acceptance, pointer moves past the completed requester.
  logic        m_pend = 1'b0;
  logic        m_prio = 1'b0;
  logic        m_who = 1'b0;
  int          m_rsp_at = 0;
  logic [4:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_sh;
  logic [31:0] m_data;
  logic        m_ovf;
  logic        m_err;
  logic        m_lg;
  logic [1:0]  m_er;
  logic [1:0]  m_ev;
  logic [32:0] m_r;
  int          m_grants[$];

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_ovf", bus.rsp_ovf, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      m_pend = 1'b0;
      m_prio = 1'b0;
    end else begin
      m_er = m_pend ? 2'b00 : mgrant(bus.req_valid, m_prio);
      m_ev = (m_pend && cyc >= m_rsp_at) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", bus.req_ready, m_er);
      chk("busy", busy, m_pend);
      chk("rsp_valid", bus.rsp_valid, m_ev);
      if (m_ev != 2'b00) begin
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_ovf", bus.rsp_ovf, m_ovf);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (m_pend && cyc < m_rsp_at) begin
        chk("alu_op", bus.alu_op, m_op);
        chk("alu_a", bus.alu_a, m_a);
        chk("alu_b", bus.alu_b, m_b);
        chk("alu_shamt", bus.alu_shamt, m_sh);
      end
      if (m_ev != 2'b00) begin
        if (bus.rsp_ready[m_who]) begin
          m_pend = 1'b0;
          m_prio = ~m_who;
        end
      end else if (!m_pend && m_er != 2'b00) begin
        m_who = m_er[1];
        m_op  = m_who ? bus.req1_op : bus.req0_op;
        m_a   = m_who ? bus.req1_a : bus.req0_a;
        m_b   = m_who ? bus.req1_b : bus.req0_b;
        m_sh  = m_who ? bus.req1_shamt : bus.req0_shamt;
        m_lg  = (m_op <= 5'd5);
        m_r   = alu_ref(m_op, m_a, m_b, m_sh);
        m_data = m_lg ? m_r[31:0] : 32'd0;
        m_ovf  = (m_lg && m_op <= 5'd1) ? m_r[32] : 1'b0;
        m_err  = ~m_lg;
        m_rsp_at = cyc + (m_lg ? 2 : 1);
        m_pend = 1'b1;
        m_grants.push_back(int'(m_who));
      end
    end
  end

  task automatic drive();
    bus.req_valid = {q1.size() != 0, q0.size() != 0};
    if (q0.size() != 0) begin
      bus.req0_op = q0[0].op; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_shamt = q0[0].sh;
    end
    if (q1.size() != 0) begin
      bus.req1_op = q1[0].op; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_shamt = q1[0].sh;
    end
  endtask

  // One clock: log accepts/completions at negedge, advance request queues after posedge.
  task automatic step(output logic [1:0] acc);
    rl_t e;
    @(negedge clock);
    acc = bus.req_valid & bus.req_ready;
    if (acc != 2'b00) begin
      grant_log.push_back(int'(acc[1]));
      acc_at[int'(acc[1])] = cyc;
    end
    if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
      e.who  = int'(bus.rsp_valid[1]);
      e.data = bus.rsp_data;
      e.ovf  = bus.rsp_ovf;
      e.err  = bus.rsp_err;
      e.lat  = cyc - acc_at[e.who];
      rsp_log.push_back(e);
    end
    @(posedge clock);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_idle(input int budget);
    logic [1:0] a;
    int n;
    n = 0;
    do begin
      step(a);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget);
    chk("idle_reached", {31'd0, (q0.size() != 0 || q1.size() != 0 || busy)}, 0);
  endtask

  task automatic chk_rsp(input string nm, input int idx, input int who, input logic [31:0] data,
                         input logic ovf, input logic err, input int lat);
    chk({nm, "_count"}, rsp_log.size() > idx, 1);
    if (rsp_log.size() > idx) begin
      chk({nm, "_who"}, rsp_log[idx].who, who);
      chk({nm, "_data"}, rsp_log[idx].data, data);
      chk({nm, "_ovf"}, rsp_log[idx].ovf, ovf);
      chk({nm, "_err"}, rsp_log[idx].err, err);
      if (lat >= 0) chk({nm, "_lat"}, rsp_log[idx].lat, lat);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_accept(input int who, input int budget);
    logic [1:0] a;
    int n;
    n = 0;
    do begin
      step(a);
      n++;
    end while (!a[who] && n < budget);
    chk("accept_seen", a[who], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] a;
    int n;
    int exp_g[8];
    logic [31:0] exp_d[8];
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp_d = '{32'd3, 32'd7, 32'h0000F000, 32'h80000000, 32'hF8000000, 32'h30, 32'hFF, 32'hFFFFFFFF};

    bus.req_valid = 2'b00;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_shamt = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_shamt = '0;
    bus.rsp_ready = 2'b11;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_rsp_data", bus.rsp_data, 0);
    step(a); step(a);

    // Single ADD on requester 0.
    clear_logs();
    q0.push_back(mk(5'd0, 32'd7, 32'd5, 5'd0)); drive();
    run_idle(20);
    chk_rsp("add", 0, 0, 32'd12, 1'b0, 1'b0, 2);

    // SUB overflow and SLL on requester 1.
    clear_logs();
    q1.push_back(mk(5'd1, 32'h80000000, 32'd1, 5'd0)); drive();
    run_idle(20);
    chk_rsp("sub_ovf", 0, 1, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
    clear_logs();
    q1.push_back(mk(5'd4, 32'd1, 32'd0, 5'd31)); drive();
    run_idle(20);
    chk_rsp("sll", 0, 1, 32'h80000000, 1'b0, 1'b0, 2);

    // Continuous contention, four ops each.
    clear_logs();
    m_grants.delete();
    q0.push_back(mk(5'd0, 32'd1, 32'd2, 5'd0));
    q0.push_back(mk(5'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0));
    q0.push_back(mk(5'd5, 32'h80000000, 32'd0, 5'd4));
    q0.push_back(mk(5'd3, 32'h0F, 32'hF0, 5'd0));
    q1.push_back(mk(5'd1, 32'd10, 32'd3, 5'd0));
    q1.push_back(mk(5'd0, 32'h7FFFFFFF, 32'd1, 5'd0));
    q1.push_back(mk(5'd4, 32'd3, 32'd0, 5'd4));
    q1.push_back(mk(5'd1, 32'd0, 32'd1, 5'd0));
    drive();
    run_idle(100);
    chk("cont_grants", grant_log.size(), 8);
    chk("cont_model_grants", m_grants.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk("cont_grant_order", grant_log[i], exp_g[i]);
      if (i < m_grants.size()) chk("cont_model_order", m_grants[i], exp_g[i]);
      if (i < rsp_log.size()) begin
        chk("cont_rsp_who", rsp_log[i].who, exp_g[i]);
        chk("cont_rsp_data", rsp_log[i].data, exp_d[i]);
      end
    end
    chk_rsp("cont_ovf", 3, 1, 32'h80000000, 1'b1, 1'b0, 2);

    // Illegal opcode: rejected one cycle after accept, consumes a turn.
    clear_logs();
    q0.push_back(mk(5'b01010, 32'd123, 32'd4, 5'd0)); drive();
    run_idle(20);
    chk_rsp("illegal", 0, 0, 32'd0, 1'b0, 1'b1, 1);
    clear_logs();
    q0.push_back(mk(5'd0, 32'd2, 32'd2, 5'd0));
    q1.push_back(mk(5'd3, 32'd1, 32'd2, 5'd0));
    drive();
    run_idle(40);
    chk("prio_flip_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk_rsp("after_illegal", 0, 1, 32'd3, 1'b0, 1'b0, 2);

    // Response backpressure on requester 0 while requester 1 waits.
    clear_logs();
    bus.rsp_ready = 2'b10;
    q0.push_back(mk(5'd0, 32'd100, 32'd23, 5'd0)); drive();
    wait_accept(0, 10);
    q1.push_back(mk(5'd1, 32'd50, 32'd8, 5'd0)); drive();
    n = 0;
    while (bus.rsp_valid[0] !== 1'b1 && n < 10) begin step(a); n++; end
    for (int k = 0; k < 5; k++) begin
      step(a);
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_rsp_data", bus.rsp_data, 32'd123);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_busy", busy, 1);
    end
    bus.rsp_ready = 2'b11;
    run_idle(30);
    chk_rsp("bp_r0", 0, 0, 32'd123, 1'b0, 1'b0, -1);
    chk_rsp("bp_r1", 1, 1, 32'd42, 1'b0, 1'b0, 2);

    // Reset during EXEC abandons the op and clears the pointer.
    q0.push_back(mk(5'd3, 32'd0, 32'd0, 5'd0)); drive();
    run_idle(20);
    q0.push_back(mk(5'd0, 32'd9, 32'd9, 5'd0)); drive();
    wait_accept(0, 10);
    #2;
    chk("mid_busy_before", busy, 1);
    chk("mid_alu_a_before", bus.alu_a, 32'd9);
    reset_n = 1'b0;
    #1;
    q0.delete(); q1.delete(); drive();
    chk("mid_req_ready", bus.req_ready, 0);
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rsp_data", bus.rsp_data, 0);
    chk("mid_rsp_ovf", bus.rsp_ovf, 0);
    chk("mid_rsp_err", bus.rsp_err, 0);
    chk("mid_busy", busy, 0);
    chk("mid_alu_op", bus.alu_op, 0);
    chk("mid_alu_a", bus.alu_a, 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    clear_logs();
    repeat (5) step(a);
    chk("mid_no_stale_rsp", rsp_log.size(), 0);
    q0.push_back(mk(5'd0, 32'd1, 32'd1, 5'd0));
    q1.push_back(mk(5'd0, 32'd2, 32'd2, 5'd0));
    drive();
    run_idle(40);
    chk("mid_prio_reset", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk_rsp("mid_r0", 0, 0, 32'd2, 1'b0, 1'b0, 2);
    chk_rsp("mid_r1", 1, 1, 32'd4, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
